// File: rtl/counter_pkg.sv
// Shared counter definitions: direction encoding used by
// the board-demo counters and their benches.
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prescaler.sv
// Free-running N-bit prescaler with a registered tick pulse.
// Ports: CLK clock, RSTN sync active-low reset,
//        CLR sync restart, TICK one-cycle pulse every 2**N clocks.
module prescaler #(
    parameter int N = 22
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic CLR,
    output logic TICK
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    // Tick is flagged while the count sits at all-ones and shows
    // up one cycle later, so the output comes straight off a flop.
    always_comb begin
        cnt_d  = cnt_q + ONE;
        tick_d = &cnt_q;
        if (CLR) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign TICK = tick_q;

endmodule

// File: rtl/prescaled_counter.sv
// Prescaled up/down wrap counter with load; optional ping-pong
// mode under macro PRESCALED_COUNTER_PINGPONG_EN.
// Ports: CLK, RSTN (sync, active-low), EN, DIR, LOAD, DIN[W],
//        PP in; Q[W], TC, TICK registered out.
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int             W   = 8,
    parameter int             N   = 22,
    parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         EN,
    input  logic         DIR,
    input  logic         LOAD,
    input  logic [W-1:0] DIN,
    input  logic         PP,
    output logic [W-1:0] Q,
    output logic         TC,
    output logic         TICK
);

    localparam logic [W-1:0] ONE = W'(1);

    logic         tick;
    logic [W-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic [W-1:0] din_c;
    logic         up;
    logic         at_end;
    logic         bounce;

    prescaler #(
        .N (N)
    ) u_pre (
        .CLK  (CLK),
        .RSTN (RSTN),
        .CLR  (LOAD),
        .TICK (tick)
    );

`ifdef PRESCALED_COUNTER_PINGPONG_EN
    logic dir_q, dir_d;
`else
    logic unused_pp;
    assign unused_pp = PP;
`endif

    assign din_c = (DIN > MAX) ? MAX : DIN;

    always_comb begin
        q_d    = q_q;
        tc_d   = 1'b0;
        up     = (DIR == DIR_UP);
        bounce = 1'b0;
`ifdef PRESCALED_COUNTER_PINGPONG_EN
        dir_d  = dir_q;
        if (PP) begin
            up     = (dir_q == DIR_UP);
            bounce = 1'b1;
        end
`endif
        at_end = up ? (q_q == MAX) : (q_q == '0);
        if (LOAD) begin
            q_d = din_c;
        end else if (tick && EN) begin
            if (at_end) begin
                tc_d = 1'b1;
                // Ping-pong steps back from the end instead of
                // wrapping, so the end value is held for one step.
                if (bounce) begin
                    q_d = up ? (q_q - ONE) : (q_q + ONE);
`ifdef PRESCALED_COUNTER_PINGPONG_EN
                    dir_d = up ? DIR_DOWN : DIR_UP;
`endif
                end else begin
                    q_d = up ? '0 : MAX;
                end
            end else begin
                q_d = up ? (q_q + ONE) : (q_q - ONE);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
`ifdef PRESCALED_COUNTER_PINGPONG_EN
            dir_q <= DIR_UP;
`endif
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
`ifdef PRESCALED_COUNTER_PINGPONG_EN
            dir_q <= dir_d;
`endif
        end
    end

    assign Q    = q_q;
    assign TC   = tc_q;
    assign TICK = tick;

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter (W=4, MAX=9, N=1).
// Per-cycle scoreboard plus directed scenario checks.
module tb_prescaled_counter;

    localparam int W   = 4;
    localparam int N   = 1;
    localparam int MAX = 9;

    typedef struct packed {
        logic [W-1:0] q;
        logic         tc;
        logic         tick;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RSTN, EN, DIR, LOAD, PP;
    logic [W-1:0] DIN;
    logic [W-1:0] Q;
    logic         TC, TICK;

    int tests = 0;
    int fails = 0;

    exp_t sb[$];

    int m_ps, m_q;
    logic m_tick, m_tc, m_dir;

    prescaled_counter #(
        .W   (W),
        .N   (N),
        .MAX (4'(MAX))
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (EN),
        .DIR  (DIR),
        .LOAD (LOAD),
        .DIN  (DIN),
        .PP   (PP),
        .Q    (Q),
        .TC   (TC),
        .TICK (TICK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model();
        logic nt;
        if (!RSTN) begin
            m_ps = 0; m_tick = 0; m_q = 0;
            m_tc = 0; m_dir = 0;
        end else if (LOAD) begin
            m_q    = (int'(DIN) > MAX) ? MAX : int'(DIN);
            m_ps   = 0;
            m_tick = 0;
            m_tc   = 0;
        end else begin
            nt   = (m_ps == (1 << N) - 1);
            m_ps = (m_ps + 1) % (1 << N);
            m_tc = 0;
            if (m_tick && EN) begin
`ifdef PRESCALED_COUNTER_PINGPONG_EN
                if (PP) begin
                    if (!m_dir) begin
                        if (m_q == MAX) begin
                            m_q = MAX - 1; m_dir = 1; m_tc = 1;
                        end else m_q = m_q + 1;
                    end else begin
                        if (m_q == 0) begin
                            m_q = 1; m_dir = 0; m_tc = 1;
                        end else m_q = m_q - 1;
                    end
                end else
`endif
                begin
                    if (!DIR) begin
                        if (m_q == MAX) begin
                            m_q = 0; m_tc = 1;
                        end else m_q = m_q + 1;
                    end else begin
                        if (m_q == 0) begin
                            m_q = MAX; m_tc = 1;
                        end else m_q = m_q - 1;
                    end
                end
            end
            m_tick = nt;
        end
    endtask

    task automatic step();
        exp_t e;
        model();
        e.q    = 4'(m_q);
        e.tc   = m_tc;
        e.tick = m_tick;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check("sb_q",    32'(Q),    32'(e.q));
        check("sb_tc",   32'(TC),   32'(e.tc));
        check("sb_tick", 32'(TICK), 32'(e.tick));
    endtask

    task automatic wait_tick();
        int b = 0;
        while (TICK !== 1'b1 && b < 64) begin
            step();
            b++;
        end
        check("tick_wait", 32'(TICK), 32'd1);
    endtask

    task automatic count_step();
        wait_tick();
        step();
    endtask

    initial begin
        int ticks;
        RSTN = 1'b0; EN = 1'b1; DIR = 1'b0;
        LOAD = 1'b0; PP = 1'b0; DIN = '0;

        // reset then first tick 2 cycles after release
        repeat (3) step();
        check("rst_q",    32'(Q),    32'd0);
        check("rst_tc",   32'(TC),   32'd0);
        check("rst_tick", 32'(TICK), 32'd0);
        RSTN = 1'b1;
        step();
        check("rel_tick1", 32'(TICK), 32'd0);
        step();
        check("rel_tick2", 32'(TICK), 32'd1);
        check("rel_q2",    32'(Q),    32'd0);
        step();
        check("rel_q3",    32'(Q),    32'd1);

        // up count and wrap
        for (int i = 2; i <= MAX; i++) begin
            count_step();
            check("up_q",  32'(Q),  32'(i));
            check("up_tc", 32'(TC), 32'd0);
        end
        count_step();
        check("wrap_q",  32'(Q),  32'd0);
        check("wrap_tc", 32'(TC), 32'd1);
        step();
        check("wrap_tc_off", 32'(TC), 32'd0);

        // down wrap
        DIR = 1'b1;
        count_step();
        check("dn_wrap_q",  32'(Q),  32'd9);
        check("dn_wrap_tc", 32'(TC), 32'd1);
        count_step();
        check("dn_q8", 32'(Q), 32'd8);
        count_step();
        check("dn_q7", 32'(Q), 32'd7);

        // load on a tick cycle, clamped, prescaler restarted
        wait_tick();
        LOAD = 1'b1; DIN = 4'd12;
        step();
        LOAD = 1'b0;
        check("ld_q",    32'(Q),    32'd9);
        check("ld_tc",   32'(TC),   32'd0);
        check("ld_tick", 32'(TICK), 32'd0);
        step();
        check("ld_tick1", 32'(TICK), 32'd0);
        step();
        check("ld_tick2", 32'(TICK), 32'd1);

        // load 5 with EN low, then hold for 10 cycles
        LOAD = 1'b1; DIN = 4'd5; EN = 1'b0;
        step();
        LOAD = 1'b0;
        check("ld5_q", 32'(Q), 32'd5);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_q", 32'(Q), 32'd5);
            if (TICK === 1'b1) ticks++;
        end
        check("hold_ticks", 32'(ticks), 32'd5);

        // reset in the middle of counting
        EN = 1'b1; DIR = 1'b0;
        repeat (5) step();
        RSTN = 1'b0;
        step();
        check("mid_rst_q",    32'(Q),    32'd0);
        check("mid_rst_tick", 32'(TICK), 32'd0);
        RSTN = 1'b1;
        step();
        check("mid_rel_tick1", 32'(TICK), 32'd0);
        step();
        check("mid_rel_tick2", 32'(TICK), 32'd1);

        // ping-pong stimulus from 7 with DIR=1
        LOAD = 1'b1; DIN = 4'd7; PP = 1'b1; DIR = 1'b1;
        step();
        LOAD = 1'b0;
        check("pp_ld_q", 32'(Q), 32'd7);
`ifdef PRESCALED_COUNTER_PINGPONG_EN
        count_step();
        check("pp_q8",  32'(Q),  32'd8);
        count_step();
        check("pp_q9",  32'(Q),  32'd9);
        check("pp_tc9", 32'(TC), 32'd0);
        count_step();
        check("pp_rev_q",  32'(Q),  32'd8);
        check("pp_rev_tc", 32'(TC), 32'd1);
        count_step();
        check("pp_q7", 32'(Q), 32'd7);
`else
        count_step();
        check("nopp_q6", 32'(Q), 32'd6);
        count_step();
        check("nopp_q5", 32'(Q), 32'd5);
        count_step();
        check("nopp_q4", 32'(Q), 32'd4);
        check("nopp_tc", 32'(TC), 32'd0);
`endif

        // random traffic against the scoreboard model
        for (int i = 0; i < 400; i++) begin
            EN   = ($urandom_range(0, 3) != 0);
            DIR  = ($urandom_range(0, 7) == 0) ? ~DIR : DIR;
            PP   = ($urandom_range(0, 15) == 0) ? ~PP : PP;
            LOAD = ($urandom_range(0, 15) == 0);
            DIN  = 4'($urandom_range(0, 15));
            RSTN = ($urandom_range(0, 63) != 0);
            step();
            check("inv_q_le_max", 32'(Q <= 4'(MAX)), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter W, default 8, counter width in bits (1..32).
REQ-002 SHALL have parameter N, default 22, prescaler exponent; count tick every 2**N clocks (N>=1).
REQ-003 SHALL have parameter MAX, default 2**W-1, highest count value (1..2**W-1).
REQ-004 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port RSTN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port EN  input  1  count enable, sampled on prescaler tick.
REQ-007 SHALL have port DIR  input  1  direction: 0 up, 1 down.
REQ-008 SHALL have port LOAD  input  1  synchronous load strobe.
REQ-009 SHALL have port DIN  input  W  load value.
REQ-010 SHALL have port PP  input  1  ping-pong mode select (see Configuration).
REQ-011 SHALL have port Q  output  W  registered count value (drives LEDs).
REQ-012 SHALL have port TC  output  1  one-cycle terminal-count pulse.
REQ-013 SHALL have port TICK  output  1  one-cycle prescaler tick pulse (heartbeat pin).

Function
REQ-014 SHALL run an N-bit prescaler incrementing every clock; TICK=1 for exactly the cycle after the prescaler reaches 2**N-1.
REQ-015 SHALL update Q only in the cycle TICK=1 and EN=1; otherwise Q holds.
REQ-016 SHALL, counting up, go Q->Q+1, and at Q==MAX go Q->0.
REQ-017 SHALL, counting down, go Q->Q-1, and at Q==0 go Q->MAX.
REQ-018 SHALL assert TC for one cycle, in the same cycle Q takes the wrapped value (MAX->0 or 0->MAX).
REQ-019 SHALL, when LOAD=1, set Q=min(DIN,MAX) next cycle regardless of TICK/EN, clear the prescaler, and not assert TC.
REQ-020 SHALL give LOAD priority over a simultaneous tick; RSTN priority over everything.
REQ-021 SHALL apply DIR changes at the next counting tick only; no glitch on Q.
REQ-022 SHALL keep Q<=MAX at all times, including after load and reset.

Reset
REQ-023 SHALL, with RSTN=0 at a rising CLK edge, set Q=0, TC=0, TICK=0, prescaler=0, ping-pong direction=up.
REQ-024 SHALL honour reset mid-count or mid-load; first tick after release occurs 2**N clocks after RSTN rises.

Configuration
REQ-025 SHALL implement ping-pong mode only when macro PRESCALED_COUNTER_PINGPONG_EN is defined.
REQ-026 SHALL, with macro defined and PP=1, ignore DIR, reverse internal direction at MAX (up->down) and at 0 (down->up) instead of wrapping, pulse TC at each reversal; PP=0 behaves as REQ-016/017.
REQ-027 SHALL, with macro undefined, ignore PP, synthesise no direction flag, and behave per REQ-016/017 only.

Structure
REQ-028 SHALL place direction encoding constants (DIR_UP=0, DIR_DOWN=1) in shared package counter_pkg.
REQ-029 SHALL implement the prescaler as sub-module prescaler (parameter N, ports CLK, RSTN, CLR, TICK), reusable by other board demos.
REQ-030 SHALL keep all outputs registered; no combinational path from inputs to Q or TC.

Verification (W=4, MAX=9, N=1 unless stated)
REQ-031 SHALL check reset: RSTN=0 for 3 cycles then 1, EN=1, DIR=0 -> Q=0, first TICK at cycle 2 after release, Q=1 one cycle later.
REQ-032 SHALL check up-wrap: count from 0 -> Q sequence 0..9,0; TC high exactly one cycle as Q becomes 0.
REQ-033 SHALL check down-wrap: DIR=1 from Q=0 -> Q=9, TC pulse; then 8,7.
REQ-034 SHALL check load: DIN=12 with LOAD on a TICK cycle -> Q=9 next cycle, no TC, prescaler restarted; DIN=5 -> Q=5.
REQ-035 SHALL check EN=0 for 10 cycles -> Q constant, TICK still pulses every 2 cycles.
REQ-036 SHALL check ping-pong (macro defined, PP=1, DIR=1 ignored): from Q=7 -> 8,9,8,7; TC at reversal; with macro undefined same stimulus -> 6,5,4 (down count per DIR).
